// File: rtl/xif_sig_pkg.sv
// -----------------------------------------------------------------------------
// xif_sig_pkg
// Shared types for the X-interface signature coprocessor.
//   xif_sig_state_e : result-channel FSM state (IDLE / WAIT / RESP)
//   xif_sig_entry_t : one outstanding-instruction tracking entry
//   sig_update()    : rotate-left-by-one then XOR signature step
// Ids are stored at XIF_SIG_ID_W_MAX bits so the entry type does not depend on
// the coprocessor's ID_W parameter; narrower ids are zero-extended on entry.
// -----------------------------------------------------------------------------
package xif_sig_pkg;

    localparam int unsigned XIF_SIG_ID_W_MAX = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // tracking FIFO empty
        ST_WAIT = 2'd1,   // head present but not yet committed
        ST_RESP = 2'd2    // result offered on the result channel
    } xif_sig_state_e;

    typedef struct packed {
        logic [XIF_SIG_ID_W_MAX-1:0] id;
        logic [4:0]                  rd;
        logic [31:0]                 instr;
        logic                        committed;
        logic                        killed;
    } xif_sig_entry_t;

    function automatic logic [31:0] sig_update(input logic [31:0] sig,
                                               input logic [31:0] instr);
        return {sig[30:0], sig[31]} ^ instr;
    endfunction

endpackage

// File: rtl/xif_sig_if.sv
// -----------------------------------------------------------------------------
// xif_sig_if
// Reduced X-interface bundle between a CPU and the signature coprocessor.
// Parameter: ID_W - instruction id width.
// Modports (coprocessor side):
//   coproc_compressed : compressed-instruction offload (refused here)
//   coproc_issue      : issue request / accept response
//   coproc_commit     : commit / kill of speculatively issued instructions
//   coproc_mem        : memory request channel (held idle here)
//   coproc_mem_result : memory result channel (ignored here)
//   coproc_result     : register writeback
// Handshake rule for every valid/ready pair: a transfer happens on a rising
// clock edge where valid and ready are both 1; once valid is raised, valid and
// its payload stay unchanged until that transfer. commit_valid has no ready.
// -----------------------------------------------------------------------------
interface xif_sig_if #(
    parameter int unsigned ID_W = 4
);
    // compressed channel
    logic            compressed_valid;
    logic            compressed_ready;
    logic [15:0]     compressed_req_instr;
    logic [ID_W-1:0] compressed_req_id;
    logic [31:0]     compressed_resp_instr;
    logic            compressed_resp_accept;

    // issue channel
    logic            issue_valid;
    logic            issue_ready;
    logic [31:0]     issue_req_instr;
    logic [ID_W-1:0] issue_req_id;
    logic            issue_resp_accept;
    logic            issue_resp_writeback;
    logic            issue_resp_dualwrite;
    logic            issue_resp_dualread;
    logic            issue_resp_loadstore;
    logic            issue_resp_ecswrite;
    logic            issue_resp_exc;

    // commit channel
    logic            commit_valid;
    logic [ID_W-1:0] commit_id;
    logic            commit_kill;

    // memory request channel
    logic            mem_valid;
    logic            mem_ready;
    logic [ID_W-1:0] mem_req_id;
    logic [31:0]     mem_req_addr;
    logic            mem_req_we;
    logic [3:0]      mem_req_be;
    logic [31:0]     mem_req_wdata;

    // memory result channel
    logic            mem_result_valid;
    logic [ID_W-1:0] mem_result_id;
    logic [31:0]     mem_result_rdata;
    logic            mem_result_err;

    // result channel
    logic            result_valid;
    logic            result_ready;
    logic [ID_W-1:0] result_id;
    logic [31:0]     result_data;
    logic [4:0]      result_rd;
    logic            result_we;
    logic [2:0]      result_ecswe;
    logic [5:0]      result_ecsdata;
    logic            result_exc;
    logic [5:0]      result_exccode;

    modport coproc_compressed (
        input  compressed_valid, compressed_req_instr, compressed_req_id,
        output compressed_ready, compressed_resp_instr, compressed_resp_accept
    );

    modport coproc_issue (
        input  issue_valid, issue_req_instr, issue_req_id,
        output issue_ready, issue_resp_accept, issue_resp_writeback,
               issue_resp_dualwrite, issue_resp_dualread, issue_resp_loadstore,
               issue_resp_ecswrite, issue_resp_exc
    );

    modport coproc_commit (
        input  commit_valid, commit_id, commit_kill
    );

    modport coproc_mem (
        input  mem_ready,
        output mem_valid, mem_req_id, mem_req_addr, mem_req_we, mem_req_be,
               mem_req_wdata
    );

    modport coproc_mem_result (
        input  mem_result_valid, mem_result_id, mem_result_rdata, mem_result_err
    );

    modport coproc_result (
        input  result_ready,
        output result_valid, result_id, result_data, result_rd, result_we,
               result_ecswe, result_ecsdata, result_exc, result_exccode
    );

endinterface

// File: rtl/xif_sig_fifo.sv
// -----------------------------------------------------------------------------
// xif_sig_fifo
// In-order tracking storage for outstanding accepted instructions, with an
// id-matched flag update used by the commit channel.
// Parameters: DEPTH (power of two), entry_t (tracking entry type), CNT_W.
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   push_i, push_entry_i append an entry at the tail
//   pop_i                drop the head entry
//   upd_valid_i/_id_i    mark every occupied entry whose id matches
//   upd_kill_i           1: set killed, 0: set committed
//   head_o, empty_o, full_o, count_o  status
// -----------------------------------------------------------------------------
module xif_sig_fifo
    import xif_sig_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = xif_sig_entry_t,
    parameter int unsigned CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        push_i,
    input  entry_t                      push_entry_i,
    input  logic                        pop_i,
    input  logic                        upd_valid_i,
    input  logic [XIF_SIG_ID_W_MAX-1:0] upd_id_i,
    input  logic                        upd_kill_i,
    output entry_t                      head_o,
    output logic                        empty_o,
    output logic                        full_o,
    output logic [CNT_W-1:0]            count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    entry_t               mem_q [DEPTH];
    logic [DEPTH-1:0]     valid_q;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;

    // Pointers are PTR_W bits wide, so they wrap modulo DEPTH naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_i);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
        count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Only occupied slots are marked: an entry pushed on the same edge
            // as a commit for its id starts with clean flags.
            for (int i = 0; i < DEPTH; i++) begin
                if (upd_valid_i && valid_q[i] && (mem_q[i].id == upd_id_i)) begin
                    if (upd_kill_i) begin
                        mem_q[i].killed <= 1'b1;
                    end else begin
                        mem_q[i].committed <= 1'b1;
                    end
                end
            end
            // Push and pop never address the same slot: that would need the
            // FIFO to be both non-empty and non-full with equal pointers.
            if (push_i) begin
                mem_q[wr_ptr_q]   <= push_entry_i;
                valid_q[wr_ptr_q] <= 1'b1;
            end
            if (pop_i) begin
                valid_q[rd_ptr_q] <= 1'b0;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;

endmodule

// File: rtl/xif_sig_coproc.sv
// -----------------------------------------------------------------------------
// xif_sig_coproc
// X-interface coprocessor that claims one major opcode and returns a running
// 32-bit signature: on each result, sig = rotl1(sig) ^ instr, written to rd.
// Results are produced strictly in issue order once committed; killed
// instructions are dropped without a result.
// Parameters: DEPTH, ID_W, OPCODE, SIG_INIT.
// Ports:
//   clk_i, rst_ni                     clock, async active-low reset
//   xif_compressed                    refused (ready 0, response zero)
//   xif_issue / xif_commit            issue handshake, commit/kill
//   xif_mem / xif_mem_result          held idle / ignored
//   xif_result                        writeback
//   dbg_state_o, dbg_sig_o, dbg_count_o  FSM state, signature, FIFO fill
// Build option: XIF_SIG_CLEAR_EN - an accepted instruction with
// funct3 == 3'b111 resets the signature to SIG_INIT instead of updating it.
// -----------------------------------------------------------------------------
module xif_sig_coproc
    import xif_sig_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned ID_W     = 4,
    parameter logic [6:0]  OPCODE   = 7'h6F,
    parameter logic [31:0] SIG_INIT = 32'h0
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    xif_sig_if.coproc_compressed       xif_compressed,
    xif_sig_if.coproc_issue            xif_issue,
    xif_sig_if.coproc_commit           xif_commit,
    xif_sig_if.coproc_mem              xif_mem,
    xif_sig_if.coproc_mem_result       xif_mem_result,
    xif_sig_if.coproc_result           xif_result,
    output xif_sig_state_e             dbg_state_o,
    output logic [31:0]                dbg_sig_o,
    output logic [$clog2(DEPTH):0]     dbg_count_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    xif_sig_state_e    state_q;
    logic [31:0]       sig_q;
    logic              res_valid_q;
    logic [ID_W-1:0]   res_id_q;
    logic [4:0]        res_rd_q;
    logic [31:0]       res_data_q;

    xif_sig_entry_t    head;
    xif_sig_entry_t    push_entry;
    logic              fifo_empty;
    logic              fifo_full;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  count_after;
    logic              accept;
    logic              push;
    logic              pop;
    logic              resp_hs;
    logic              drop_killed;
    logic              head_ready;
    logic              use_clear;
    logic [31:0]       head_data;

    // ---------------- issue side ----------------
    assign accept = (xif_issue.issue_req_instr[6:0] == OPCODE);
    assign push   = xif_issue.issue_valid && !fifo_full && accept;

    always_comb begin
        push_entry           = '0;
        push_entry.id        = XIF_SIG_ID_W_MAX'(xif_issue.issue_req_id);
        push_entry.rd        = xif_issue.issue_req_instr[11:7];
        push_entry.instr     = xif_issue.issue_req_instr;
        push_entry.committed = 1'b0;
        push_entry.killed    = 1'b0;
    end

    assign xif_issue.issue_ready          = !fifo_full;
    assign xif_issue.issue_resp_accept    = accept;
    assign xif_issue.issue_resp_writeback = accept;
    assign xif_issue.issue_resp_dualwrite = 1'b0;
    assign xif_issue.issue_resp_dualread  = 1'b0;
    assign xif_issue.issue_resp_loadstore = 1'b0;
    assign xif_issue.issue_resp_ecswrite  = 1'b0;
    assign xif_issue.issue_resp_exc       = 1'b0;

    // ---------------- tracking storage ----------------
    xif_sig_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (xif_sig_entry_t),
        .CNT_W   (CNT_W)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .upd_valid_i  (xif_commit.commit_valid),
        .upd_id_i     (XIF_SIG_ID_W_MAX'(xif_commit.commit_id)),
        .upd_kill_i   (xif_commit.commit_kill),
        .head_o       (head),
        .empty_o      (fifo_empty),
        .full_o       (fifo_full),
        .count_o      (fifo_count)
    );

    // ---------------- result side ----------------
    // The head is popped either on the result handshake or, outside RESP,
    // silently when it has been killed (killed wins over committed).
    assign resp_hs     = (state_q == ST_RESP) && xif_result.result_ready;
    assign drop_killed = (state_q != ST_RESP) && !fifo_empty && head.killed;
    assign head_ready  = (state_q != ST_RESP) && !fifo_empty &&
                         head.committed && !head.killed;
    assign pop         = resp_hs || drop_killed;
    assign count_after = fifo_count + CNT_W'(push) - CNT_W'(pop);

`ifdef XIF_SIG_CLEAR_EN
    assign use_clear = (head.instr[14:12] == 3'b111);
`else
    assign use_clear = 1'b0;
`endif

    // The payload is computed once on entry to RESP. sig_q cannot change while
    // a result is pending, so the held data stays consistent.
    assign head_data = use_clear ? SIG_INIT : sig_update(sig_q, head.instr);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            sig_q       <= SIG_INIT;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_rd_q    <= '0;
            res_data_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_WAIT: begin
                    if (head_ready) begin
                        state_q     <= ST_RESP;
                        res_valid_q <= 1'b1;
                        res_id_q    <= head.id[ID_W-1:0];
                        res_rd_q    <= head.rd;
                        res_data_q  <= head_data;
                    end else begin
                        state_q <= (count_after == '0) ? ST_IDLE : ST_WAIT;
                    end
                end
                ST_RESP: begin
                    if (xif_result.result_ready) begin
                        sig_q       <= res_data_q;
                        res_valid_q <= 1'b0;
                        state_q     <= (count_after == '0) ? ST_IDLE : ST_WAIT;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    res_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign xif_result.result_valid   = res_valid_q;
    assign xif_result.result_id      = res_id_q;
    assign xif_result.result_rd      = res_rd_q;
    assign xif_result.result_data    = res_data_q;
    assign xif_result.result_we      = res_valid_q;
    assign xif_result.result_ecswe   = '0;
    assign xif_result.result_ecsdata = '0;
    assign xif_result.result_exc     = 1'b0;
    assign xif_result.result_exccode = '0;

    // ---------------- unused channels ----------------
    assign xif_compressed.compressed_ready       = 1'b0;
    assign xif_compressed.compressed_resp_instr  = '0;
    assign xif_compressed.compressed_resp_accept = 1'b0;

    assign xif_mem.mem_valid     = 1'b0;
    assign xif_mem.mem_req_id    = '0;
    assign xif_mem.mem_req_addr  = '0;
    assign xif_mem.mem_req_we    = 1'b0;
    assign xif_mem.mem_req_be    = '0;
    assign xif_mem.mem_req_wdata = '0;

    logic unused_inputs;
    assign unused_inputs = ^{xif_compressed.compressed_valid,
                             xif_compressed.compressed_req_instr,
                             xif_compressed.compressed_req_id,
                             xif_mem.mem_ready,
                             xif_mem_result.mem_result_valid,
                             xif_mem_result.mem_result_id,
                             xif_mem_result.mem_result_rdata,
                             xif_mem_result.mem_result_err,
                             head.id[XIF_SIG_ID_W_MAX-1:ID_W]};

    assign dbg_state_o = state_q;
    assign dbg_sig_o   = sig_q;
    assign dbg_count_o = fifo_count;

endmodule

// File: tb/tb_xif_sig_coproc.sv
module tb_xif_sig_coproc;
  import xif_sig_pkg::*;

  localparam int          DEPTH    = 4;
  localparam int          ID_W     = 4;
  localparam logic [6:0]  OPC      = 7'h6F;
  localparam logic [31:0] SIG_INIT = 32'h0;
  localparam int          LAT_LIM  = DEPTH + 4;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  xif_sig_if #(.ID_W(ID_W)) xif ();
  xif_sig_state_e dbg_state;
  logic [31:0]    dbg_sig;
  logic [2:0]     dbg_count;

  xif_sig_coproc #(
    .DEPTH(DEPTH), .ID_W(ID_W), .OPCODE(OPC), .SIG_INIT(SIG_INIT)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .xif_compressed (xif),
    .xif_issue      (xif),
    .xif_commit     (xif),
    .xif_mem        (xif),
    .xif_mem_result (xif),
    .xif_result     (xif),
    .dbg_state_o    (dbg_state),
    .dbg_sig_o      (dbg_sig),
    .dbg_count_o    (dbg_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h expected=%h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [ID_W-1:0] id;
    logic [31:0]     instr;
    bit              committed;
  } m_ent_t;

  m_ent_t      mq[$];          // live (not killed) accepted instructions, issue order
  logic [31:0] m_sig;

  function automatic logic [31:0] expect_data(input logic [31:0] s, input logic [31:0] instr);
    logic [31:0] rot;
    rot = (s << 1) | (s >> 31);
`ifdef XIF_SIG_CLEAR_EN
    if (instr[14:12] == 3'b111) return SIG_INIT;
`endif
    return rot ^ instr;
  endfunction

  function automatic bit id_in_q(input logic [ID_W-1:0] id);
    foreach (mq[i]) if (mq[i].id == id) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------- scoreboard / compare process ----------------
  bit          prev_valid, prev_ready;
  logic [40:0] prev_pl;
  int          stall;

  always @(negedge clk_i) begin
    logic [40:0] cur_pl;
    bit          eligible;
    if (!rst_ni) begin
      mq.delete();
      m_sig      = SIG_INIT;
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      stall      = 0;
    end else begin
      cur_pl = {xif.result_id, xif.result_rd, xif.result_data};
      chk("idle_channels", {31'b0, |{xif.compressed_ready, xif.compressed_resp_accept,
          xif.compressed_resp_instr, xif.mem_valid, xif.mem_req_id, xif.mem_req_addr,
          xif.mem_req_we, xif.mem_req_be, xif.mem_req_wdata, xif.issue_resp_dualwrite,
          xif.issue_resp_dualread, xif.issue_resp_loadstore, xif.issue_resp_ecswrite,
          xif.issue_resp_exc}}, 32'h0);
      chk("issue_accept", xif.issue_resp_accept, xif.issue_req_instr[6:0] == OPC);
      chk("issue_writeback", xif.issue_resp_writeback, xif.issue_req_instr[6:0] == OPC);
      chk("issue_ready", xif.issue_ready, dbg_count < DEPTH);
      chk("occupancy", (dbg_count >= mq.size()) && (dbg_count <= DEPTH), 1);

      if (xif.result_valid) begin
        chk("result_head_committed", (mq.size() > 0) && mq[0].committed, 1);
        if (mq.size() > 0) begin
          chk("result_id", xif.result_id, mq[0].id);
          chk("result_rd", xif.result_rd, mq[0].instr[11:7]);
          chk("result_data", xif.result_data, expect_data(m_sig, mq[0].instr));
          chk("result_we", xif.result_we, 1);
          chk("result_exc_fields", {xif.result_ecswe, xif.result_ecsdata,
              xif.result_exc, xif.result_exccode}, 0);
        end
      end
      if (prev_valid && !prev_ready) begin
        chk("result_hold_valid", xif.result_valid, 1);
        chk("result_hold_payload", cur_pl === prev_pl, 1);
      end

      eligible = (mq.size() > 0) && mq[0].committed && !xif.result_valid;
      stall = eligible ? stall + 1 : 0;
      if (eligible) chk("result_latency", stall <= LAT_LIM, 1);

      // handshakes that take effect on the coming rising edge
      if (xif.commit_valid) begin
        for (int i = mq.size() - 1; i >= 0; i--) begin
          if (mq[i].id == xif.commit_id) begin
            if (xif.commit_kill) mq.delete(i);
            else mq[i].committed = 1'b1;
          end
        end
      end
      if (xif.result_valid && xif.result_ready && mq.size() > 0) begin
        m_sig = expect_data(m_sig, mq[0].instr);
        void'(mq.pop_front());
      end
      if (xif.issue_valid && xif.issue_ready && xif.issue_req_instr[6:0] == OPC)
        mq.push_back('{id: xif.issue_req_id, instr: xif.issue_req_instr, committed: 1'b0});

      prev_valid = xif.result_valid;
      prev_ready = xif.result_ready;
      prev_pl    = cur_pl;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic reset_dut();
    rst_ni = 1'b0;
    xif.issue_valid = 1'b0; xif.commit_valid = 1'b0; xif.result_ready = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  task automatic issue_one(input logic [31:0] instr, input logic [ID_W-1:0] id);
    int n;
    xif.issue_valid = 1'b1; xif.issue_req_instr = instr; xif.issue_req_id = id;
    n = 0;
    @(negedge clk_i);
    while (!xif.issue_ready && n < 20) begin @(negedge clk_i); n++; end
    if (n >= 20) chk("issue_timeout", 0, 1);
    tick();
    xif.issue_valid = 1'b0;
  endtask

  task automatic commit_one(input logic [ID_W-1:0] id, input logic kill);
    xif.commit_valid = 1'b1; xif.commit_id = id; xif.commit_kill = kill;
    tick();
    xif.commit_valid = 1'b0;
  endtask

  task automatic wait_result();
    int n;
    n = 0;
    @(negedge clk_i);
    while (!xif.result_valid && n < 30) begin @(negedge clk_i); n++; end
    if (n >= 30) chk("result_timeout", 0, 1);
  endtask

  task automatic take_result();
    tick();
    xif.result_ready = 1'b1;
    tick();
    xif.result_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int seen;
    int done;
    logic [ID_W-1:0] nid;
    logic [31:0]     instr;
    int              cand[$];

    xif.compressed_valid = 0; xif.compressed_req_instr = 0; xif.compressed_req_id = 0;
    xif.issue_valid = 0; xif.issue_req_instr = 0; xif.issue_req_id = 0;
    xif.commit_valid = 0; xif.commit_id = 0; xif.commit_kill = 0;
    xif.mem_ready = 0; xif.mem_result_valid = 0; xif.mem_result_id = 0;
    xif.mem_result_rdata = 0; xif.mem_result_err = 0; xif.result_ready = 0;

    reset_dut();
    @(negedge clk_i);
    chk("rst_result_valid", xif.result_valid, 0);
    chk("rst_issue_ready", xif.issue_ready, 1);
    chk("rst_sig", dbg_sig, SIG_INIT);
    chk("rst_count", dbg_count, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    tick();

    // single accepted instruction
    issue_one(32'h0000006F, 4'd1);
    commit_one(4'd1, 1'b0);
    wait_result();
    chk("t034_id", xif.result_id, 1);
    chk("t034_rd", xif.result_rd, 0);
    chk("t034_data", xif.result_data, 32'h0000006F);
    take_result();
    @(negedge clk_i);
    chk("t034_sig", dbg_sig, 32'h0000006F);
    tick();

    // rejected opcode
    reset_dut();
    xif.issue_valid = 1'b1; xif.issue_req_instr = 32'h00000033; xif.issue_req_id = 4'd5;
    @(negedge clk_i);
    chk("t035_accept", xif.issue_resp_accept, 0);
    tick();
    xif.issue_valid = 1'b0;
    seen = 0;
    repeat (4) begin @(negedge clk_i); if (xif.result_valid) seen++; end
    chk("t035_count", dbg_count, 0);
    chk("t035_no_result", seen, 0);
    tick();

    // fill to DEPTH, then drain head
    reset_dut();
    for (int i = 1; i <= DEPTH; i++) issue_one(32'h0000006F, ID_W'(i));
    xif.issue_valid = 1'b1; xif.issue_req_instr = 32'h0000006F; xif.issue_req_id = 4'd5;
    @(negedge clk_i);
    chk("t036_full_ready", xif.issue_ready, 0);
    tick();
    xif.issue_valid = 1'b0;
    commit_one(4'd1, 1'b0);
    wait_result();
    chk("t036_id1", xif.result_id, 1);
    chk("t036_data1", xif.result_data, 32'h0000006F);
    take_result();
    @(negedge clk_i);
    chk("t036_ready_again", xif.issue_ready, 1);
    tick();
    commit_one(4'd2, 1'b0);
    wait_result();
    chk("t036_id2", xif.result_id, 2);
    chk("t036_data2", xif.result_data, 32'h000000B1);
    take_result();

    // kill then commit
    reset_dut();
    issue_one(32'h0000006F, 4'd2);
    issue_one(32'h0000006F, 4'd3);
    commit_one(4'd2, 1'b1);
    commit_one(4'd3, 1'b0);
    wait_result();
    chk("t037_id", xif.result_id, 3);
    chk("t037_data", xif.result_data, 32'h0000006F);
    take_result();
    seen = 0;
    repeat (6) begin @(negedge clk_i); if (xif.result_valid) seen++; end
    chk("t037_single_result", seen, 0);
    chk("t037_empty", dbg_count, 0);
    tick();

    // back-pressure on result
    reset_dut();
    issue_one(32'h0000006F, 4'd1);
    commit_one(4'd1, 1'b0);
    wait_result();
    repeat (5) begin
      @(negedge clk_i);
      chk("t038_valid", xif.result_valid, 1);
      chk("t038_data", xif.result_data, 32'h0000006F);
      chk("t038_sig_held", dbg_sig, SIG_INIT);
    end
    take_result();
    @(negedge clk_i);
    chk("t038_sig_after", dbg_sig, 32'h0000006F);
    tick();

    // reset with work outstanding
    reset_dut();
    issue_one(32'h0000006F, 4'd7);
    issue_one(32'h0000016F, 4'd8);
    commit_one(4'd7, 1'b0);
    rst_ni = 1'b0;
    @(negedge clk_i);
    chk("t039_result_valid", xif.result_valid, 0);
    chk("t039_issue_ready", xif.issue_ready, 1);
    chk("t039_sig", dbg_sig, SIG_INIT);
    chk("t039_count", dbg_count, 0);
    tick();
    rst_ni = 1'b1;
    tick();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      xif.issue_valid = ($urandom_range(0, 1) == 1);
      nid = ID_W'($urandom_range(0, 15));
      for (int k = 0; k < 64; k++) begin
        if (!id_in_q(nid)) break;
        nid = ID_W'($urandom_range(0, 15));
      end
      instr = $urandom;
      if ($urandom_range(0, 3) != 0) instr[6:0] = OPC;
      xif.issue_req_instr = instr;
      xif.issue_req_id    = nid;

      xif.commit_valid = 1'b0;
      if ($urandom_range(0, 2) == 0) begin
        cand.delete();
        foreach (mq[i]) if (!mq[i].committed) cand.push_back(i);
        xif.commit_kill  = ($urandom_range(0, 3) == 0);
        xif.commit_valid = 1'b1;
        if (cand.size() > 0) begin
          xif.commit_id = mq[cand[$urandom_range(0, cand.size() - 1)]].id;
        end else begin
          nid = ID_W'($urandom_range(0, 15));
          for (int k = 0; k < 64; k++) begin
            if (!id_in_q(nid)) break;
            nid = ID_W'($urandom_range(0, 15));
          end
          xif.commit_id = nid;
        end
      end
      xif.result_ready = ($urandom_range(0, 1) == 1);
      tick();
    end

    // drain
    xif.issue_valid  = 1'b0;
    xif.result_ready = 1'b1;
    done = 0;
    for (int c = 0; c < 500 && !done; c++) begin
      xif.commit_valid = 1'b0;
      foreach (mq[i]) begin
        if (!mq[i].committed && !xif.commit_valid) begin
          xif.commit_valid = 1'b1; xif.commit_id = mq[i].id; xif.commit_kill = 1'b0;
        end
      end
      tick();
      if (mq.size() == 0 && dbg_count == 0 && !xif.result_valid) done = 1;
    end
    xif.commit_valid = 1'b0;
    chk("drain_complete", done, 1);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: actual=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/xif_sig_coproc.md
XIF_SIG_COPROC -- requirements
Module: xif_sig_coproc

Interface
REQ-001 SHALL have parameter DEPTH, default 4: outstanding-instruction tracking entries; power of two, 2..16.
REQ-002 SHALL have parameter ID_W, default 4: width of X-interface instruction id.
REQ-003 SHALL have parameter OPCODE, default 7'h6F: 7-bit major opcode claimed by this coprocessor.
REQ-004 SHALL have parameter SIG_INIT, default 32'h0: signature register value after reset.
REQ-005 SHALL have port clk_i, input, 1: single clock, rising edge.
REQ-006 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port xif_compressed, modport coproc_compressed, -: compressed channel, always refused.
REQ-008 SHALL have port xif_issue, modport coproc_issue, -: issue request/response.
REQ-009 SHALL have port xif_commit, modport coproc_commit, -: commit/kill.
REQ-010 SHALL have port xif_mem, modport coproc_mem, -: memory request channel, unused, driven idle.
REQ-011 SHALL have port xif_mem_result, modport coproc_mem_result, -: memory result channel, ignored.
REQ-012 SHALL have port xif_result, modport coproc_result, -: result writeback.

Function
REQ-013 compressed_ready=0, compressed_resp all-zero; mem_valid=0, mem_req all-zero, constant.
REQ-014 issue_ready SHALL be 1 when tracking FIFO not full, 0 when full; combinational, no dependence on issue_valid.
REQ-015 accept SHALL be 1 iff instr[6:0]==OPCODE; writeback=accept; dualwrite/dualread/loadstore/ecswrite/exc=0.
REQ-016 Issue handshake = issue_valid & issue_ready; if accept, push {id, rd=instr[11:7], instr, committed=0, killed=0} same edge.
REQ-017 Rejected instruction (accept=0) SHALL not push and SHALL not alter state.
REQ-018 Commit handshake (commit_valid) SHALL mark every FIFO entry with matching id: commit_kill=1 sets killed, else sets committed; no match -> ignored.
REQ-019 Result FSM states: IDLE (FIFO empty), WAIT (head not committed/killed), RESP (result_valid=1).
REQ-020 WAIT->RESP when head committed and not killed; head killed -> pop silently in 1 cycle, stay/return to WAIT or IDLE.
REQ-021 In RESP: result.id=head id, rd=head rd, we=1, data=signature updated with head instr, ecs*/exc/exccode=0.
REQ-022 Signature update: sig_next = {sig[30:0],sig[31]} ^ instr, committed on result handshake (result_valid & result_ready), head popped same edge.
REQ-023 result_valid SHALL hold stable with unchanged payload until result_ready; result_ready while IDLE/WAIT ignored.
REQ-024 Simultaneous push and pop SHALL keep count unchanged; push while full impossible (issue_ready=0).
REQ-025 Commit for head entry in same cycle as it is checked SHALL take effect next cycle (registered flags).
REQ-026 Pointers SHALL wrap modulo DEPTH; count width clog2(DEPTH)+1.
REQ-027 Result latency: head committed at cycle N -> result_valid at N+1 minimum.

Reset
REQ-028 On rst_ni low: FIFO empty, pointers/count 0, all flags 0, FSM IDLE, sig=SIG_INIT, result_valid=0, issue_ready=1.
REQ-029 Reset mid-operation SHALL discard all outstanding entries without emitting results.

Configuration
REQ-030 Macro XIF_SIG_CLEAR_EN defined: accepted instr with funct3 (instr[14:12])==3'b111 clears sig to SIG_INIT on its result handshake, result.data=SIG_INIT.
REQ-031 Macro undefined: funct3 ignored, every accepted instr updates sig per REQ-022.

Structure
REQ-032 Shared package xif_sig_pkg SHALL hold the FSM state enum and the tracking-entry struct typedef.
REQ-033 Sub-module xif_sig_fifo (parametrised DEPTH, entry type, id-match flag update) SHALL hold the tracking storage.

Verification
REQ-034 Issue instr 32'h0000006F id=1, commit id=1 kill=0 -> accept=1, result id=1 rd=0 data=32'h0000006F.
REQ-035 Issue instr 32'h00000033 -> accept=0, no result, count stays 0.
REQ-036 Issue 4 accepted, no commits (DEPTH=4) -> issue_ready=0 on 5th; commit id of head, take result -> issue_ready=1.
REQ-037 Issue id=2,3; kill id=2, commit id=3 -> only one result, id=3, data=32'h0000006F.
REQ-038 Hold result_ready=0 5 cycles in RESP -> result_valid/payload stable; sig unchanged until handshake.
REQ-039 Assert rst_ni low with 2 entries outstanding -> result_valid=0, issue_ready=1, sig=SIG_INIT next cycle.
